acumulador_serial: RTL and testbench



---
 rtl/acumulador_serial.sv | 134 +++++++++++++
 tb/tb_acumulador_serial.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acumulador_serial.sv
// ============================================================================
// Module   : acumulador_serial (with helper adder somador)
// Purpose  : Frame accumulator over valid/ready; sums TAM-bit operands via
//            somador, reports total, saturating beat count and overflow.
//            Optional macro ACUM_SATURATE_EN clamps the total to all-ones on carry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module somador #(
  parameter int TAM = 8
) (
  input  logic [TAM-1:0] a,
  input  logic [TAM-1:0] b,
  output logic [TAM-1:0] s
);
  assign s = a + b;
endmodule

module acumulador_serial #(
  parameter int TAM  = 8,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [TAM-1:0]  in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TAM-1:0]  out_sum,
  output logic [CNTW-1:0] out_cnt,
  output logic            out_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] c_cnt_max  = '1;
  localparam logic [CNTW-1:0] c_cnt_one  = CNTW'(1);
  localparam logic [TAM-1:0]  c_all_ones = '1;

  state_t          r_state, w_state_nxt;
  logic [TAM-1:0]  r_acc, w_acc_nxt;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  logic            r_ovf, w_ovf_nxt;
  logic [TAM-1:0]  w_sum;
  logic            w_carry;
  logic            w_beat;

  somador #(.TAM(TAM)) u_somador (
    .a (r_acc),
    .b (in_data),
    .s (w_sum)
  );

  // A wrapped sum is always smaller than the value it started from.
  assign w_carry  = (w_sum < r_acc);
  assign in_ready = (r_state != ST_DONE);
  assign out_valid = (r_state == ST_DONE);
  assign w_beat   = in_valid && in_ready;

  assign out_sum = r_acc;
  assign out_cnt = r_cnt;
  assign out_ovf = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      ST_IDLE: begin
        if (w_beat) begin
          w_acc_nxt   = in_data;
          w_cnt_nxt   = c_cnt_one;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = in_last ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        if (w_beat) begin
`ifdef ACUM_SATURATE_EN
          w_acc_nxt = w_carry ? c_all_ones : w_sum;
`else
          w_acc_nxt = w_sum;
`endif
          w_cnt_nxt   = (r_cnt == c_cnt_max) ? c_cnt_max : r_cnt + c_cnt_one;
          w_ovf_nxt   = r_ovf | w_carry;
          w_state_nxt = in_last ? ST_DONE : ST_ACC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_acc_nxt   = '0;
        w_cnt_nxt   = '0;
        w_ovf_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Only referenced when saturation is enabled.
  logic w_unused;
  assign w_unused = ^c_all_ones;

endmodule

`default_nettype wire

// File: tb/tb_acumulador_serial.sv
// Testbench for acumulador_serial: directed scenarios plus random frames
// checked against an arithmetic reference model.
`default_nettype none

module tb_acumulador_serial;

  localparam int TAM  = 8;
  localparam int CNTW = 4;
`ifdef ACUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [TAM-1:0]  in_data = '0;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [TAM-1:0]  out_sum;
  logic [CNTW-1:0] out_cnt;
  logic            out_ovf;

  int errors = 0;
  int checks = 0;
  int frame_q[$];

  acumulador_serial #(.TAM(TAM), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer sum with either wrap or clamp on overflow.
  task automatic model(output logic [TAM-1:0] s, output logic [CNTW-1:0] c, output logic o);
    int acc = 0;
    o = 1'b0;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i == 0) acc = frame_q[0];
      else if (acc + frame_q[i] > 255) begin
        o = 1'b1;
        acc = SAT ? 255 : acc + frame_q[i] - 256;
      end else acc = acc + frame_q[i];
    end
    c = (frame_q.size() > 15) ? 4'd15 : CNTW'(frame_q.size());
    s = acc[TAM-1:0];
  endtask

  // Drives frame_q; returns at the negedge one cycle after the last beat is taken.
  task automatic run_frame(input int gap_pct, output bit timeout);
    int idx = 0;
    int guard = 0;
    logic rdy;
    timeout = 1'b0;
    while (idx < frame_q.size()) begin
      @(negedge clk);
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = TAM'($urandom);
        in_last  = 1'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = TAM'(frame_q[idx]);
        in_last  = (idx == frame_q.size() - 1);
      end
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) idx++;
      guard++;
      if (guard > 2000) begin
        timeout = 1'b1;
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Holds the result for wait_cycles, acks, and reports state one cycle later.
  task automatic ack_result(input int wait_cycles, output logic v_after, output logic r_after);
    repeat (wait_cycles) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    v_after = out_valid;
    r_after = in_ready;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_sum !== 8'd0) begin errors++; $display("FAIL reset_sum got=%0d want=0", out_sum); end
    checks++; if (out_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", out_cnt); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", out_ovf); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit to; logic v, r;
    frame_q = '{3, 5, 7};
    run_frame(0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got=%b want=0", to); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency out_valid got=%b want=1", out_valid); end
    checks++; if (out_sum !== 8'd15) begin errors++; $display("FAIL basic_sum got=%0d want=15", out_sum); end
    checks++; if (out_cnt !== 4'd3) begin errors++; $display("FAIL basic_cnt got=%0d want=3", out_cnt); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%b want=0", out_ovf); end
    ack_result(0, v, r);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL basic_release out_valid got=%b want=0", v); end
  endtask

  task automatic test_overflow;
    bit to; logic v, r;
    logic [TAM-1:0] exp_s;
    frame_q = '{200, 100};
    run_frame(0, to);
    exp_s = SAT ? 8'd255 : 8'd44;
    checks++; if (out_sum !== exp_s || to) begin errors++; $display("FAIL ovf2_sum got=%0d want=%0d", out_sum, exp_s); end
    checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL ovf2_flag got=%b want=1", out_ovf); end
    ack_result(1, v, r);
    frame_q = '{200, 100, 10};
    run_frame(0, to);
    exp_s = SAT ? 8'd255 : 8'd54;
    checks++; if (out_sum !== exp_s || to) begin errors++; $display("FAIL ovf3_sum got=%0d want=%0d", out_sum, exp_s); end
    checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL ovf3_flag got=%b want=1", out_ovf); end
    checks++; if (out_cnt !== 4'd3) begin errors++; $display("FAIL ovf3_cnt got=%0d want=3", out_cnt); end
    ack_result(0, v, r);
  endtask

  task automatic test_hold;
    bit to;
    frame_q = '{42};
    run_frame(0, to);
    checks++; if (out_valid !== 1'b1 || to) begin errors++; $display("FAIL single_valid got=%b want=1", out_valid); end
    checks++; if (out_cnt !== 4'd1) begin errors++; $display("FAIL single_cnt got=%0d want=1", out_cnt); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL single_ovf got=%b want=0", out_ovf); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = TAM'($urandom);
      in_last  = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_handshake cyc=%0d valid=%b ready=%b want valid=1 ready=0", i, out_valid, in_ready);
      end
      checks++; if (out_sum !== 8'd42 || out_cnt !== 4'd1) begin
        errors++; $display("FAIL hold_data cyc=%0d sum=%0d cnt=%0d want 42/1", i, out_sum, out_cnt);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_cnt_saturation;
    bit to; logic v, r;
    frame_q = {};
    for (int i = 0; i < 20; i++) frame_q.push_back(1);
    run_frame(0, to);
    checks++; if (out_sum !== 8'd20 || to) begin errors++; $display("FAIL cntsat_sum got=%0d want=20", out_sum); end
    checks++; if (out_cnt !== 4'd15) begin errors++; $display("FAIL cntsat_cnt got=%0d want=15", out_cnt); end
    ack_result(0, v, r);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL cntsat_ready got=%b want=1", r); end
  endtask

  task automatic test_reset_mid;
    bit to; logic v, r;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'd50; in_last = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (out_sum !== 8'd0 || out_cnt !== 4'd0 || out_ovf !== 1'b0) begin
      errors++; $display("FAIL rstmid_regs sum=%0d cnt=%0d ovf=%b want 0/0/0", out_sum, out_cnt, out_ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    frame_q = '{9};
    run_frame(0, to);
    checks++; if (out_sum !== 8'd9 || out_cnt !== 4'd1 || to) begin
      errors++; $display("FAIL rstmid_after sum=%0d cnt=%0d want 9/1", out_sum, out_cnt);
    end
    // Reset while a result is held must drop it without a handshake.
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 8'd0) begin
      errors++; $display("FAIL rstdone valid=%b ready=%b sum=%0d want 0/1/0", out_valid, in_ready, out_sum);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_gaps;
    bit to; logic v, r;
    frame_q = '{1, 2, 3, 4};
    run_frame(50, to);
    checks++; if (out_sum !== 8'd10 || to) begin errors++; $display("FAIL gaps_sum got=%0d want=10", out_sum); end
    checks++; if (out_cnt !== 4'd4) begin errors++; $display("FAIL gaps_cnt got=%0d want=4", out_cnt); end
    ack_result(2, v, r);
  endtask

  task automatic test_random;
    bit to; logic v, r;
    logic [TAM-1:0] es; logic [CNTW-1:0] ec; logic eo;
    for (int f = 0; f < 40; f++) begin
      frame_q = {};
      for (int i = 0; i < int'($urandom_range(20, 1)); i++)
        frame_q.push_back(($urandom_range(1) == 1) ? int'($urandom_range(255)) : int'($urandom_range(15)));
      model(es, ec, eo);
      run_frame(int'($urandom_range(60)), to);
      checks++; if (to !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL rand_valid frame=%0d got=%b want=1", f, out_valid);
      end
      checks++; if (out_sum !== es || out_cnt !== ec || out_ovf !== eo) begin
        errors++; $display("FAIL rand_result frame=%0d sum=%0d cnt=%0d ovf=%b want %0d/%0d/%b",
                           f, out_sum, out_cnt, out_ovf, es, ec, eo);
      end
      ack_result(int'($urandom_range(3)), v, r);
      checks++; if (v !== 1'b0 || r !== 1'b1) begin
        errors++; $display("FAIL rand_release frame=%0d valid=%b ready=%b want 0/1", f, v, r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_hold();
    test_cnt_saturation();
    test_reset_mid();
    test_gaps();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
